// File: rtl/sdram_arb_pkg.sv
// rtl/sdram_arb_pkg.sv - shared types and defaults for the two-port SDRAM request arbiter
package sdram_arb_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_ACTIVE
  } state_t;

  typedef enum logic {
    PORT_CPU,
    PORT_DL
  } port_t;

  localparam int SLOT_LEN_DEF = 8;

endpackage

// File: rtl/sdram_arb_port.sv
// rtl/sdram_arb_port.sv - one-entry request buffer: strobe capture, pend/busy, overflow flag
module sdram_arb_port #(
  parameter int ADDR_W = 25
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              strobe,
  input  logic              strobe_we,
  input  logic [ADDR_W-1:0] strobe_addr,
  input  logic [7:0]        strobe_data,
  input  logic              clear,
  output logic              pend,
  output logic              we,
  output logic [ADDR_W-1:0] addr,
  output logic [7:0]        data,
  output logic              ovf
);

  // pend doubles as busy: it rises after the accepting edge and drops on the completing edge
  always_ff @(posedge clk) begin
    if (reset) begin
      pend <= 1'b0;
      we   <= 1'b0;
      addr <= '0;
      data <= '0;
      ovf  <= 1'b0;
    end else begin
      if (clear)
        pend <= 1'b0;
      if (strobe && !pend) begin
        pend <= 1'b1;
        we   <= strobe_we;
        addr <= strobe_addr;
        data <= strobe_data;
      end else if (strobe) begin
        ovf  <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - CPU/download arbiter granting one request per clkref slot
// Download port compiled in only when SDRAM_ARB_DL_EN is defined.
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W   = 25,
  parameter int SLOT_LEN = SLOT_LEN_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clkref,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_din,
  output logic [7:0]        cpu_dout,
  output logic              cpu_busy,
  output logic              cpu_ack,
  input  logic              dl_wr,
  input  logic [ADDR_W-1:0] dl_addr,
  input  logic [7:0]        dl_data,
  output logic              dl_busy,
  output logic              dl_ovf,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_din,
  input  logic [7:0]        mem_dout,
  output logic              mem_oe,
  output logic              mem_we
);

  localparam int unused_slot_len = SLOT_LEN;

  state_t state, state_n;
  port_t  gnt, last_grant, start_port;

  logic              clkref_d, cref_rise;
  logic              start, complete, cpu_clr, dl_clr, cpu_elig, dl_elig;
  logic              cpu_pend, cpu_we_b, cpu_ovf;
  logic [ADDR_W-1:0] cpu_addr_b;
  logic [7:0]        cpu_data_b;
  logic              dl_pend, dl_we_b;
  logic [ADDR_W-1:0] dl_addr_b;
  logic [7:0]        dl_data_b;
  logic              unused_cpu_ovf;

  assign cref_rise      = clkref & ~clkref_d;
  assign unused_cpu_ovf = cpu_ovf;

  sdram_arb_port #(.ADDR_W(ADDR_W)) u_cpu (
    .clk(clk), .reset(reset), .strobe(cpu_req), .strobe_we(cpu_we),
    .strobe_addr(cpu_addr), .strobe_data(cpu_din), .clear(cpu_clr),
    .pend(cpu_pend), .we(cpu_we_b), .addr(cpu_addr_b), .data(cpu_data_b), .ovf(cpu_ovf)
  );

`ifdef SDRAM_ARB_DL_EN
  sdram_arb_port #(.ADDR_W(ADDR_W)) u_dl (
    .clk(clk), .reset(reset), .strobe(dl_wr), .strobe_we(1'b1),
    .strobe_addr(dl_addr), .strobe_data(dl_data), .clear(dl_clr),
    .pend(dl_pend), .we(dl_we_b), .addr(dl_addr_b), .data(dl_data_b), .ovf(dl_ovf)
  );
`else
  logic unused_dl;
  assign unused_dl = ^{dl_wr, dl_addr, dl_data, dl_clr};
  assign dl_pend   = 1'b0;
  assign dl_we_b   = 1'b0;
  assign dl_addr_b = '0;
  assign dl_data_b = '0;
  assign dl_ovf    = 1'b0;
`endif

  assign cpu_busy = cpu_pend;
  assign dl_busy  = dl_pend;

  always_ff @(posedge clk) begin
    if (reset)
      state <= ST_IDLE;
    else
      state <= state_n;
  end

  // The port being completed still shows pend at this edge, so it is excluded from re-grant
  always_comb begin
    state_n    = state;
    start      = 1'b0;
    start_port = PORT_CPU;
    complete   = 1'b0;
    cpu_elig   = cpu_pend && !(state == ST_ACTIVE && gnt == PORT_CPU);
    dl_elig    = dl_pend  && !(state == ST_ACTIVE && gnt == PORT_DL);
    if (cref_rise) begin
      complete = (state == ST_ACTIVE);
      if (cpu_elig && dl_elig) begin
        start      = 1'b1;
        start_port = (last_grant == PORT_CPU) ? PORT_DL : PORT_CPU;
      end else if (cpu_elig) begin
        start      = 1'b1;
        start_port = PORT_CPU;
      end else if (dl_elig) begin
        start      = 1'b1;
        start_port = PORT_DL;
      end
      state_n = start ? ST_ACTIVE : ST_IDLE;
    end
  end

  assign cpu_clr = complete && (gnt == PORT_CPU);
  assign dl_clr  = complete && (gnt == PORT_DL);

  always_ff @(posedge clk) begin
    if (reset) begin
      clkref_d   <= 1'b0;
      gnt        <= PORT_CPU;
      last_grant <= PORT_CPU;
      mem_addr   <= '0;
      mem_din    <= '0;
      mem_oe     <= 1'b0;
      mem_we     <= 1'b0;
      cpu_dout   <= '0;
      cpu_ack    <= 1'b0;
    end else begin
      clkref_d <= clkref;
      cpu_ack  <= cpu_clr;
      if (cpu_clr && mem_oe)
        cpu_dout <= mem_dout;
      if (start) begin
        gnt        <= start_port;
        last_grant <= start_port;
        if (start_port == PORT_DL) begin
          mem_addr <= dl_addr_b;
          mem_din  <= dl_data_b;
          mem_we   <= dl_we_b;
          mem_oe   <= ~dl_we_b;
        end else begin
          mem_addr <= cpu_addr_b;
          mem_din  <= cpu_data_b;
          mem_we   <= cpu_we_b;
          mem_oe   <= ~cpu_we_b;
        end
      end else if (cref_rise) begin
        mem_oe <= 1'b0;
        mem_we <= 1'b0;
      end
    end
  end

endmodule
